// File: rtl/sobel_pkg.sv
// Shared types for the Sobel window sequencer: pixel width, FSM states, 3x3 window.
// Latency: none; this package holds declarations only.
// Backpressure: none; no handshakes are declared here.
package sobel_pkg;

   localparam int DATA_W = 8;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2,
      DONE  = 2'd3
   } state_t;

   // Row-major 3x3 neighbourhood: p0 is the oldest pixel of the oldest row, p8 the newest pixel.
   typedef struct packed {
      logic [DATA_W-1:0] p0;
      logic [DATA_W-1:0] p1;
      logic [DATA_W-1:0] p2;
      logic [DATA_W-1:0] p3;
      logic [DATA_W-1:0] p4;
      logic [DATA_W-1:0] p5;
      logic [DATA_W-1:0] p6;
      logic [DATA_W-1:0] p7;
      logic [DATA_W-1:0] p8;
   } window_t;

endpackage

// File: rtl/sobel_line_buf.sv
// One image line of pixels held in a circular store addressed by the column counter.
// Latency: read is combinational (previous line's pixel); write lands on the next rising edge.
// Backpressure: none; the caller's step strobe qualifies every write.
module sobel_line_buf #(
   parameter int IMG_W  = 64,
   parameter int DATA_W = 8,
   localparam int AW    = $clog2(IMG_W)
) (
   input  logic              clk,
   input  logic              we,
   input  logic [AW-1:0]     addr,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);
   import sobel_pkg::*;

   logic [DATA_W-1:0] mem [IMG_W];

   assign rdata = mem[addr];

   // Replace this column's entry after its old value has been read out for the current step
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

endmodule

// File: rtl/sobel_window_ctrl.sv
// Sequences a raster pixel stream into 3x3 windows for the Gradient block and returns one edge bit per pixel.
// Latency: pixel accepted at edge k gives its edge bit on out_data from edge k+1; one pixel per cycle.
// Backpressure: in_ready drops combinationally when stage 1 and the output register are full and out_ready is low.
module sobel_window_ctrl #(
   parameter int IMG_W  = 64,
   parameter int IMG_H  = 64,
   parameter int DATA_W = sobel_pkg::DATA_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [DATA_W-1:0] thresh,
   input  logic [DATA_W-1:0] in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [DATA_W-1:0] win_p0,
   output logic [DATA_W-1:0] win_p1,
   output logic [DATA_W-1:0] win_p2,
   output logic [DATA_W-1:0] win_p3,
   output logic [DATA_W-1:0] win_p4,
   output logic [DATA_W-1:0] win_p5,
   output logic [DATA_W-1:0] win_p6,
   output logic [DATA_W-1:0] win_p7,
   output logic [DATA_W-1:0] win_p8,
   output logic [DATA_W-1:0] t_o,
   input  logic              dop_i,
   output logic              out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic              busy,
   output logic              done
);
   import sobel_pkg::*;

   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(IMG_H);
   localparam int FW = $clog2(IMG_W + 1);
   localparam logic [CW-1:0] COL_LAST = CW'(IMG_W - 1);
   localparam logic [RW-1:0] ROW_LAST = RW'(IMG_H - 1);
   localparam logic [FW-1:0] FL_LAST  = FW'(IMG_W);

   state_t            state, state_nxt;
   logic [CW-1:0]     in_col, o_col;
   logic [RW-1:0]     in_row, o_row;
   logic [FW-1:0]     fl_cnt;
   logic [DATA_W-1:0] t_q, pix, lb1_rd, lb2_rd;
   window_t           win;
   logic              s1_vld, s1_border;
   logic              out_ok, s1_free, step, started, last_pix, drained, border_nxt;

   // Output register can take a new bit when empty or being drained; stage 1 is free when empty or moving out.
   assign out_ok     = !out_valid || out_ready;
   assign s1_free    = !s1_vld || out_ok;
   assign drained    = !s1_vld && out_ok;
   assign last_pix   = (in_row == ROW_LAST) && (in_col == COL_LAST);
   assign pix        = (state == RUN) ? in_data : '0;
   assign border_nxt = (o_row == '0) || (o_row == ROW_LAST) || (o_col == '0) || (o_col == COL_LAST);

   sobel_line_buf #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb1 (
      .clk   (clk),
      .we    (step),
      .addr  (in_col),
      .wdata (pix),
      .rdata (lb1_rd)
   );

   sobel_line_buf #(.IMG_W(IMG_W), .DATA_W(DATA_W)) u_lb2 (
      .clk   (clk),
      .we    (step),
      .addr  (in_col),
      .wdata (lb1_rd),
      .rdata (lb2_rd)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state, input handshake and step strobe; a window is only meaningful once W+1 pixels are in
   always_comb begin
      state_nxt = state;
      in_ready  = 1'b0;
      step      = 1'b0;
      started   = 1'b0;
      case (state)
         IDLE: begin
            if (start) state_nxt = RUN;
         end
         RUN: begin
            in_ready = s1_free;
            step     = in_valid && s1_free;
            started  = (in_row > RW'(1)) || ((in_row == RW'(1)) && (in_col != '0));
            if (step && last_pix) state_nxt = FLUSH;
         end
         FLUSH: begin
            step    = s1_free;
            started = 1'b1;
            if (step && (fl_cnt == FL_LAST)) state_nxt = DONE;
         end
         DONE: begin
            if (drained) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Threshold latch plus input, flush and output-position counters
   always_ff @(posedge clk) begin
      if (rst) begin
         t_q    <= '0;
         in_col <= '0;
         in_row <= '0;
         fl_cnt <= '0;
         o_col  <= '0;
         o_row  <= '0;
      end else if ((state == IDLE) && start) begin
         t_q    <= thresh;
         in_col <= '0;
         in_row <= '0;
         fl_cnt <= '0;
         o_col  <= '0;
         o_row  <= '0;
      end else if (step) begin
         in_col <= (in_col == COL_LAST) ? '0 : in_col + CW'(1);
         if ((state == RUN) && (in_col == COL_LAST)) in_row <= in_row + RW'(1);
         if (state == FLUSH) fl_cnt <= fl_cnt + FW'(1);
         if (started) begin
            o_col <= (o_col == COL_LAST) ? '0 : o_col + CW'(1);
            if (o_col == COL_LAST) o_row <= (o_row == ROW_LAST) ? '0 : o_row + RW'(1);
         end
      end
   end

   // Stage 1: shift the three row registers on every step; valid only once the centre is a real pixel
   always_ff @(posedge clk) begin
      if (rst) begin
         s1_vld    <= 1'b0;
         s1_border <= 1'b0;
         win       <= '0;
      end else if (step) begin
         s1_vld    <= started;
         s1_border <= border_nxt;
         win.p0    <= win.p1;
         win.p1    <= win.p2;
         win.p2    <= lb2_rd;
         win.p3    <= win.p4;
         win.p4    <= win.p5;
         win.p5    <= lb1_rd;
         win.p6    <= win.p7;
         win.p7    <= win.p8;
         win.p8    <= pix;
      end else if (out_ok) begin
         s1_vld <= 1'b0;
      end
   end

   // Output register: border centres are forced to 0 whatever Gradient says
   always_ff @(posedge clk) begin
      if (rst) begin
         out_valid <= 1'b0;
         out_data  <= 1'b0;
      end else if (out_ok) begin
         out_valid <= s1_vld;
         out_data  <= s1_vld && !s1_border && dop_i;
      end
   end

   // Done pulses once, the cycle after the final edge bit leaves the output register
   always_ff @(posedge clk) begin
      if (rst) begin
         done <= 1'b0;
      end else begin
         done <= (state == DONE) && drained;
      end
   end

   assign busy   = (state != IDLE);
   assign t_o    = t_q;
   assign win_p0 = win.p0;
   assign win_p1 = win.p1;
   assign win_p2 = win.p2;
   assign win_p3 = win.p3;
   assign win_p4 = win.p4;
   assign win_p5 = win.p5;
   assign win_p6 = win.p6;
   assign win_p7 = win.p7;
   assign win_p8 = win.p8;

endmodule

// File: tb/tb_sobel_window_ctrl.sv
// Bench for sobel_window_ctrl on a 6x5 image, with a behavioural Sobel Gradient on dop_i.
// Latency: first beat expected one edge after pixel W+1 is accepted; one bit per accepted pixel.
// Backpressure: random and burst out_ready stalls, random in_valid gaps.
module tb_sobel_window_ctrl;
   localparam int W     = 6;
   localparam int H     = 5;
   localparam int DW    = 8;
   localparam int N     = W * H;
   localparam int LIMIT = 4000;

   logic clk = 1'b0;
   logic rst, start, in_valid, in_ready, dop, out_data, out_valid, out_ready, busy, done;
   logic [DW-1:0] thresh, in_data, t_o;
   logic [DW-1:0] wp0, wp1, wp2, wp3, wp4, wp5, wp6, wp7, wp8;
   logic [9*DW-1:0] win_vec, wsnap;

   int total = 0;
   int bad = 0;
   int cyc = 0;
   int done_cnt = 0;
   int accepted = 0;
   logic ov_q = 1'b0, or_q = 1'b0;
   logic [DW-1:0] img [N];
   logic [DW-1:0] thr;
   int acc_cyc [N];
   int got_bits [$];
   logic [9*DW-1:0] got_win [$];
   int beat_cyc [$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   sobel_window_ctrl #(.IMG_W(W), .IMG_H(H), .DATA_W(DW)) dut (
      .clk(clk), .rst(rst), .start(start), .thresh(thresh),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .win_p0(wp0), .win_p1(wp1), .win_p2(wp2), .win_p3(wp3), .win_p4(wp4),
      .win_p5(wp5), .win_p6(wp6), .win_p7(wp7), .win_p8(wp8),
      .t_o(t_o), .dop_i(dop), .out_data(out_data), .out_valid(out_valid),
      .out_ready(out_ready), .busy(busy), .done(done)
   );

   assign win_vec = {wp8, wp7, wp6, wp5, wp4, wp3, wp2, wp1, wp0};

   // Sobel magnitude |Gx|+|Gy| against T; element k of w is Pk
   function automatic logic grad(input logic [9*DW-1:0] w, input logic [DW-1:0] t);
      int p [9];
      int gx, gy;
      for (int k = 0; k < 9; k++) p[k] = int'(w[k*DW +: DW]);
      gx = (p[2] + 2*p[5] + p[8]) - (p[0] + 2*p[3] + p[6]);
      gy = (p[6] + 2*p[7] + p[8]) - (p[0] + 2*p[1] + p[2]);
      if (gx < 0) gx = -gx;
      if (gy < 0) gy = -gy;
      return (gx + gy) > int'(t);
   endfunction

   always_comb dop = grad(win_vec, t_o);

   // Neighbourhood of image position n taken straight from the frame array
   function automatic logic [9*DW-1:0] ref_win(input int n);
      logic [9*DW-1:0] v;
      int r, c;
      r = n / W;
      c = n % W;
      v = '0;
      for (int dr = 0; dr < 3; dr++)
         for (int dc = 0; dc < 3; dc++)
            v[(dr*3+dc)*DW +: DW] = img[(r-1+dr)*W + (c-1+dc)];
      return v;
   endfunction

   function automatic bit is_border(input int n);
      return (n / W == 0) || (n / W == H-1) || (n % W == 0) || (n % W == W-1);
   endfunction

   function automatic int ref_bit(input int n);
      if (is_border(n)) return 0;
      return int'(grad(ref_win(n), thr));
   endfunction

   // Monitor: a new beat loads when out_valid rises or follows a handshake; the window seen before that edge made it
   always @(negedge clk) begin
      if (out_valid && (!ov_q || or_q)) begin
         got_win.push_back(wsnap);
         beat_cyc.push_back(cyc);
      end
      if (out_valid && out_ready) got_bits.push_back(int'(out_data));
      if (done) done_cnt++;
      ov_q  = out_valid;
      or_q  = out_ready;
      wsnap = win_vec;
   end

   task automatic fill_random(input int amp);
      for (int i = 0; i < N; i++) img[i] = DW'($urandom_range(amp));
   endtask

   task automatic start_frame();
      got_bits.delete();
      got_win.delete();
      beat_cyc.delete();
      done_cnt = 0;
      @(posedge clk); #1;
      start  = 1'b1;
      thresh = thr;
      @(posedge clk); #1;
      start  = 1'b0;
      thresh = ~thr;
   endtask

   task automatic drive(input int npix, input int gap_pct);
      int guard = 0;
      accepted = 0;
      while (accepted < npix && guard < LIMIT) begin
         @(posedge clk); #1;
         in_valid = ($urandom_range(99) >= gap_pct);
         in_data  = img[accepted];
         @(negedge clk);
         if (in_valid && in_ready) begin
            acc_cyc[accepted] = cyc + 1;
            accepted++;
         end
         guard++;
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
   endtask

   task automatic sink(input int stall_pct, input int stall_at, output int rdy_hi);
      int guard = 0;
      int hold = 0;
      bit used = 0;
      rdy_hi = 0;
      while (done_cnt == 0 && guard < LIMIT) begin
         @(posedge clk); #1;
         if (!used && stall_at >= 0 && got_bits.size() >= stall_at) begin
            hold = 10;
            used = 1;
         end
         if (hold > 0) begin
            out_ready = 1'b0;
            @(negedge clk);
            if (hold <= 9 && in_ready) rdy_hi++;
            hold--;
         end else begin
            out_ready = ($urandom_range(99) >= stall_pct);
         end
         guard++;
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
   endtask

   task automatic run_frame(input int gap_pct, input int stall_pct, input int stall_at, output int rdy_hi);
      start_frame();
      fork
         drive(N, gap_pct);
         sink(stall_pct, stall_at, rdy_hi);
      join
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      int rdy;
      rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = '0; thresh = '0; out_ready = 1'b1;
      repeat (3) @(posedge clk); #1;
      total++;
      if ({out_valid, out_data, in_ready, busy, done, t_o, win_vec} !== '0) begin
         bad++;
         $display("FAIL reset_init got=%h want=0", {out_valid, out_data, in_ready, busy, done, t_o, win_vec});
      end
      rst = 1'b0;
      thr = 8'd30;
      fill_random(40);
      start_frame();
      drive(12, 0);
      total++;
      if (busy !== 1'b1) begin bad++; $display("FAIL busy_run got=%b want=1", busy); end
      rst = 1'b1;
      repeat (3) @(posedge clk); #1;
      total++;
      if ({out_valid, out_data, in_ready, busy, done, t_o, win_vec} !== '0) begin
         bad++;
         $display("FAIL reset_mid got=%h want=0", {out_valid, out_data, in_ready, busy, done, t_o, win_vec});
      end
      rst = 1'b0;
      thr = DW'($urandom_range(10, 120));
      fill_random(40);
      run_frame(0, 0, -1, rdy);
      total++;
      if (got_bits.size() != N) begin bad++; $display("FAIL rst_clean_count got=%0d want=%0d", got_bits.size(), N); end
      for (int n = 0; n < got_bits.size() && n < N; n++) begin
         total++;
         if (got_bits[n] != ref_bit(n)) begin bad++; $display("FAIL rst_clean_bit[%0d] got=%0d want=%0d", n, got_bits[n], ref_bit(n)); end
      end
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL rst_clean_done got=%0d want=1", done_cnt); end
   endtask

   task automatic test_flat();
      int rdy;
      thr = 8'd20;
      for (int i = 0; i < N; i++) img[i] = 8'd100;
      run_frame(0, 0, -1, rdy);
      total++;
      if (got_bits.size() != N) begin bad++; $display("FAIL flat_count got=%0d want=%0d", got_bits.size(), N); end
      for (int n = 0; n < got_bits.size() && n < N; n++) begin
         total++;
         if (got_bits[n] != 0) begin bad++; $display("FAIL flat_bit[%0d] got=%0d want=0", n, got_bits[n]); end
      end
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL flat_done got=%0d want=1", done_cnt); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL flat_busy_after got=%b want=0", busy); end
      total++;
      if (t_o !== thr) begin bad++; $display("FAIL flat_t_o got=%0d want=%0d", t_o, thr); end
   endtask

   task automatic test_window();
      int rdy, first;
      thr = DW'($urandom_range(0, 255));
      for (int i = 0; i < N; i++) img[i] = DW'(i);
      run_frame(0, 0, -1, rdy);
      total++;
      if (got_win.size() != N) begin bad++; $display("FAIL win_beats got=%0d want=%0d", got_win.size(), N); end
      for (int n = 0; n < got_win.size() && n < N; n++) begin
         if (!is_border(n)) begin
            total++;
            if (got_win[n] !== ref_win(n)) begin bad++; $display("FAIL win[%0d] got=%h want=%h", n, got_win[n], ref_win(n)); end
         end
      end
      first = (beat_cyc.size() > 0) ? beat_cyc[0] : -1;
      total++;
      if (first != acc_cyc[W+1] + 1) begin bad++; $display("FAIL win_latency got=%0d want=%0d", first, acc_cyc[W+1] + 1); end
      for (int n = 0; n < got_bits.size() && n < N; n++) begin
         total++;
         if (got_bits[n] != ref_bit(n)) begin bad++; $display("FAIL win_bit[%0d] got=%0d want=%0d", n, got_bits[n], ref_bit(n)); end
      end
   endtask

   task automatic test_vertical_step();
      int rdy;
      logic [W-1:0] exp_row, got_row, want_row;
      exp_row = 6'b000110;
      thr = 8'd20;
      for (int i = 0; i < N; i++) img[i] = (i % W < 2) ? 8'd0 : 8'd255;
      run_frame(20, 20, -1, rdy);
      total++;
      if (got_bits.size() != N) begin bad++; $display("FAIL step_count got=%0d want=%0d", got_bits.size(), N); end
      for (int r = 0; r < H; r++) begin
         got_row = '0;
         for (int c = 0; c < W; c++)
            if (r*W + c < got_bits.size()) got_row[c] = got_bits[r*W + c][0];
         want_row = (r == 0 || r == H-1) ? '0 : exp_row;
         total++;
         if (got_row !== want_row) begin bad++; $display("FAIL step_row[%0d] got=%b want=%b", r, got_row, want_row); end
      end
   endtask

   task automatic test_random();
      int rdy;
      for (int f = 0; f < 3; f++) begin
         thr = DW'($urandom_range(10, 120));
         fill_random(40);
         run_frame(30, 30, -1, rdy);
         total++;
         if (got_bits.size() != N) begin bad++; $display("FAIL rand%0d_count got=%0d want=%0d", f, got_bits.size(), N); end
         for (int n = 0; n < got_bits.size() && n < N; n++) begin
            total++;
            if (got_bits[n] != ref_bit(n)) begin bad++; $display("FAIL rand%0d_bit[%0d] got=%0d want=%0d", f, n, got_bits[n], ref_bit(n)); end
         end
         total++;
         if (done_cnt != 1) begin bad++; $display("FAIL rand%0d_done got=%0d want=1", f, done_cnt); end
      end
   endtask

   task automatic test_backpressure();
      int rdy;
      thr = DW'($urandom_range(10, 120));
      fill_random(40);
      run_frame(0, 0, N/2, rdy);
      total++;
      if (rdy != 0) begin bad++; $display("FAIL bp_in_ready_high_cycles got=%0d want=0", rdy); end
      total++;
      if (got_bits.size() != N) begin bad++; $display("FAIL bp_count got=%0d want=%0d", got_bits.size(), N); end
      for (int n = 0; n < got_bits.size() && n < N; n++) begin
         total++;
         if (got_bits[n] != ref_bit(n)) begin bad++; $display("FAIL bp_bit[%0d] got=%0d want=%0d", n, got_bits[n], ref_bit(n)); end
      end
      for (int n = 0; n < got_win.size() && n < N; n++) begin
         if (!is_border(n)) begin
            total++;
            if (got_win[n] !== ref_win(n)) begin bad++; $display("FAIL bp_win[%0d] got=%h want=%h", n, got_win[n], ref_win(n)); end
         end
      end
   endtask

   task automatic test_abort();
      int rdy;
      thr = 8'd25;
      fill_random(40);
      out_ready = 1'b1;
      start_frame();
      drive(7, 0);
      rst = 1'b1;
      repeat (2) @(posedge clk); #1;
      rst = 1'b0;
      repeat (5) @(posedge clk); #1;
      total++;
      if (done_cnt != 0) begin bad++; $display("FAIL abort_done got=%0d want=0", done_cnt); end
      total++;
      if (busy !== 1'b0) begin bad++; $display("FAIL abort_busy got=%b want=0", busy); end
      thr = DW'($urandom_range(10, 120));
      fill_random(40);
      run_frame(10, 10, -1, rdy);
      total++;
      if (got_bits.size() != N) begin bad++; $display("FAIL abort2_count got=%0d want=%0d", got_bits.size(), N); end
      for (int n = 0; n < got_bits.size() && n < N; n++) begin
         total++;
         if (got_bits[n] != ref_bit(n)) begin bad++; $display("FAIL abort2_bit[%0d] got=%0d want=%0d", n, got_bits[n], ref_bit(n)); end
      end
      total++;
      if (done_cnt != 1) begin bad++; $display("FAIL abort2_done got=%0d want=1", done_cnt); end
   endtask

   initial begin
      test_reset();
      test_flat();
      test_window();
      test_vertical_step();
      test_random();
      test_backpressure();
      test_abort();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/sobel_window_ctrl.md
# sobel_window_ctrl

Streaming sequencer that feeds the combinational `Gradient` edge detector. It takes a raster pixel stream and keeps two line buffers. For every image position it forms a 3x3 neighbourhood, drives it onto `Gradient`'s P0..P8/T inputs, and returns one edge bit per pixel with valid/ready handshakes on both sides. It sits between the frame source and the edge-map sink in the Sobel pipeline.

## Interface
Parameters:
- `IMG_W`, 64: image width in pixels, must be ≥ 3.
- `IMG_H`, 64: image height in lines, must be ≥ 3.
- `DATA_W`, 8: pixel width; matches `Gradient` P/T width.

Ports:
- `clk`  in  1  single clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `start`  in  1  begin a frame; sampled only in IDLE.
- `thresh`  in  DATA_W  edge threshold, latched on accepted `start`.
- `in_data`  in  DATA_W  raster pixel, row-major, row 0 first.
- `in_valid`  in  1  `in_data` valid.
- `in_ready`  out  1  pixel accepted on an edge where `in_valid && in_ready`.
- `win_p0`..`win_p8`  out  DATA_W each  window to `Gradient` P0..P8.
- `t_o`  out  DATA_W  latched threshold, to `Gradient` T.
- `dop_i`  in  1  `Gradient` Dop, combinational from `win_p*`/`t_o`.
- `out_data`  out  1  edge bit for the current output position.
- `out_valid`  out  1  `out_data` valid.
- `out_ready`  in  1  sink accepts on `out_valid && out_ready`.
- `busy`  out  1  high outside IDLE.
- `done`  out  1  one-cycle pulse after the last edge bit is accepted.

## Operation
- FSM states and transitions:
  - IDLE, on `start`: latch `thresh`, clear counters, go to RUN.
  - RUN, after accepting pixel index `IMG_W*IMG_H-1`: go to FLUSH.
  - FLUSH, after `IMG_W+1` internal steps: go to DONE.
  - DONE, when the output register drains: pulse `done`, go to IDLE.
- `start` is ignored outside IDLE.
- `in_ready` is high only in RUN and only when stage 1 is empty or advancing this cycle.
- Window formation:
  - The current pixel and the two line-buffer taps shift into three 3-deep row shift registers.
  - `win_p0..p8` are row-major: P0 is (r-2,c-2) of the newest pixel (r,c), P4 is the centre (r-1,c-1), P8 is (r,c).
- Output order: one edge bit per image position, W*H bits per frame, in raster order of the centre.
  - The centre index is the accepted pixel index minus (IMG_W+1).
  - No output is produced for the first IMG_W+1 accepted pixels.
  - FLUSH supplies the final IMG_W+1 steps with dummy (zero) pixels and no input handshake.
- Border rule: a centre in row 0, row IMG_H-1, col 0 or col IMG_W-1 outputs 0 regardless of `dop_i`. The border flag travels with stage 1.
- Counters:
  - Column counter wraps at IMG_W-1 to 0 and increments the row counter.
  - Output position counter runs 0..W*H-1.

## Timing
- Reset value of every output is 0, FSM is in IDLE, and line buffers are not cleared (contents don't-care).
- Stage 1 is the window registers plus the stage-1 valid flag.
  - Stage 1 loads on pixel accept (RUN) or flush step.
  - Stage 1 moves to the output register when `!out_valid || out_ready`.
- The output register captures `border ? 0 : dop_i` from the stage-1 window.
- Latency: pixel accepted at edge k → its edge bit is valid on `out_data` from edge k+1 when unstalled. Throughput is 1 pixel/cycle.
- Backpressure: `out_ready` low with both stages full drops `in_ready` in the same cycle (combinational path). No data is lost or duplicated.
- `t_o` is stable for the whole frame.
- `rst` mid-frame aborts immediately: FSM goes to IDLE, valids clear, and no `done` is issued.

## Structure
- Package `sobel_pkg` holds:
  - `DATA_W` default.
  - FSM state enum {IDLE, RUN, FLUSH, DONE}.
  - `window_t`, a 9 × DATA_W packed struct.
- Sub-module `sobel_line_buf`:
  - IMG_W × DATA_W circular buffer, one write per step at the column counter.
  - Combinational read at the same address.
  - Instantiated twice, cascaded.

## Test plan
- Reset: hold `rst` for 3 cycles mid-stream → all outputs 0, `busy`=0, and the next `start` processes a clean frame.
- Flat frame, IMG_W=IMG_H=4, all pixels 100, T=20 → exactly 16 `out_valid` beats, all 0, and one `done` pulse.
- Window order, 4x4 raster values 0..15 → at emission of centre (1,1), P0..P8 = 0,1,2,4,5,6,8,9,10.
- Vertical step, 5x5, cols 0-1 = 0 and cols 2-4 = 255, T=20 → per-row mask 00000 / 01100 / 01100 / 01100 / 00000.
- Backpressure: `out_ready` low for 10 cycles mid-frame → `in_ready` low within 1 cycle, the bitstream equals the unstalled run, and count = W*H.
- Abort: `rst` after 7 accepted pixels, then a new `start` with 16 pixels → no `done` for the aborted frame, and the second frame's output is correct.
